// File: rtl/hwag_pkg.sv
// Shared hwag definitions: generator FSM states, config limits and width defaults
// used by both the wheel generator and the capture side.
package hwag_pkg;

   localparam int HWAG_PERIOD_W = 16;
   localparam int HWAG_TOOTH_W  = 8;

   localparam int unsigned MIN_PERIOD = 32'd2;
   localparam int unsigned MIN_TEETH  = 32'd3;

   typedef enum logic [0:0] {IDLE, RUN} hwag_gen_state_t;

   // Arguments are widened to 32 bits so missing+2 can never overflow.
   function automatic logic cfg_valid(input int unsigned period, input int unsigned high,
                                      input int unsigned teeth, input int unsigned missing);
      return (period >= MIN_PERIOD) && (high >= 32'd1) && (high < period) &&
             (teeth >= MIN_TEETH) && ((missing + 32'd2) <= teeth);
   endfunction

endpackage

// File: rtl/hwag_gen_counter.sv
// Phase/slot counter pair for the wheel generator. Next-state values are exported
// so the output stage can register raw/gap aligned with the counters.
module hwag_gen_counter #(
   parameter int PERIOD_W = 16,
   parameter int TOOTH_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [PERIOD_W-1:0] period,
   input  logic [TOOTH_W-1:0]  teeth,
   output logic [TOOTH_W-1:0]  slot,
   output logic [PERIOD_W-1:0] phase_nxt,
   output logic [TOOTH_W-1:0]  slot_nxt,
   output logic                end_rev
);

   logic [PERIOD_W-1:0] phase;
   logic                end_slot;

   assign end_slot = run && (phase == period - PERIOD_W'(1));
   assign end_rev  = end_slot && (slot == teeth - TOOTH_W'(1));

   // Counters park at zero whenever the generator is not running.
   always_comb begin
      phase_nxt = '0;
      slot_nxt  = '0;
      if (run) begin
         phase_nxt = end_slot ? '0 : phase + PERIOD_W'(1);
         if (end_rev)
            slot_nxt = '0;
         else if (end_slot)
            slot_nxt = slot + TOOTH_W'(1);
         else
            slot_nxt = slot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= '0;
         slot  <= '0;
      end else begin
         phase <= phase_nxt;
         slot  <= slot_nxt;
      end
   end

endmodule

// File: rtl/hwag_vr_gen.sv
// N-minus-M toothed-wheel generator. Config is shadowed at each revolution start so
// a reprogram mid-revolution can never produce a malformed tooth.
module hwag_vr_gen
   import hwag_pkg::*;
#(
   parameter int PERIOD_W = HWAG_PERIOD_W,
   parameter int TOOTH_W  = HWAG_TOOTH_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic                inv,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [PERIOD_W-1:0] cfg_high,
   input  logic [TOOTH_W-1:0]  cfg_teeth,
   input  logic [TOOTH_W-1:0]  cfg_missing,
   output logic                vr_out,
   output logic [TOOTH_W-1:0]  slot,
   output logic                gap,
   output logic                rev_pulse,
   output logic                busy,
   output logic                cfg_err
);

   hwag_gen_state_t     state;
   logic [PERIOD_W-1:0] sh_period, sh_high;
   logic [TOOTH_W-1:0]  sh_teeth, sh_missing;
   logic [PERIOD_W-1:0] phase_nxt;
   logic [TOOTH_W-1:0]  slot_nxt;
   logic                end_rev, live_ok, miss_nxt, raw;

   assign live_ok  = cfg_valid(32'(cfg_period), 32'(cfg_high), 32'(cfg_teeth), 32'(cfg_missing));
   assign miss_nxt = slot_nxt >= (sh_teeth - sh_missing);
   assign vr_out   = raw ^ inv;

   hwag_gen_counter #(.PERIOD_W(PERIOD_W), .TOOTH_W(TOOTH_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .run       (state == RUN),
      .period    (sh_period),
      .teeth     (sh_teeth),
      .slot      (slot),
      .phase_nxt (phase_nxt),
      .slot_nxt  (slot_nxt),
      .end_rev   (end_rev)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         raw        <= 1'b0;
         gap        <= 1'b0;
         rev_pulse  <= 1'b0;
         busy       <= 1'b0;
         cfg_err    <= 1'b0;
         sh_period  <= '0;
         sh_high    <= '0;
         sh_teeth   <= '0;
         sh_missing <= '0;
      end else begin
         rev_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (ena) begin
                  if (live_ok) begin
                     sh_period  <= cfg_period;
                     sh_high    <= cfg_high;
                     sh_teeth   <= cfg_teeth;
                     sh_missing <= cfg_missing;
                     state      <= RUN;
                     raw        <= 1'b1;
                     gap        <= 1'b0;
                     rev_pulse  <= 1'b1;
                     busy       <= 1'b1;
                     cfg_err    <= 1'b0;
                  end else begin
                     cfg_err <= 1'b1;
                     raw     <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (end_rev) begin
                  gap <= 1'b0;
                  if (!ena) begin
                     state <= IDLE;
                     raw   <= 1'b0;
                     busy  <= 1'b0;
                  end else begin
                     // Slot 0 is never missing and high >= 1, so the tooth starts high
                     // whether the new or the retained shadow config applies.
                     raw       <= 1'b1;
                     rev_pulse <= 1'b1;
                     cfg_err   <= !live_ok;
                     if (live_ok) begin
                        sh_period  <= cfg_period;
                        sh_high    <= cfg_high;
                        sh_teeth   <= cfg_teeth;
                        sh_missing <= cfg_missing;
                     end
                  end
               end else begin
                  raw <= (phase_nxt < sh_high) && !miss_nxt;
                  gap <= miss_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
